// File: rtl/ram_arbiter.sv
// ram_arbiter: shares one asynchronous 16-bit SRAM between a CPU bus master
// and a video fetch engine.
//
// Ports
//   clk, reset_n             core clock, asynchronous active-low reset
//   cpu_rd, cpu_wt           CPU read/write strobes (level, held until reply)
//   cpu_byte, cpu_adr        byte-access flag and CPU byte address
//   cpu_data_i / cpu_data_o  CPU write data / captured read word
//   cpu_reply                bus reply to the CPU
//   vid_req, vid_adr         single-cycle video fetch request and word address
//   vid_data, vid_valid      fetched video word and its one-cycle strobe
//   sram_*                   SRAM address, data, output enable and strobes
//   dbg_state_o              current arbiter state (debug)
//
// Handshake: the CPU raises cpu_rd or cpu_wt and holds it; cpu_reply rises
// when the access is complete and stays high until both strobes are low,
// then drops on the following cycle. Video requests are fire-and-forget
// pulses answered by a one-cycle vid_valid.
module ram_arbiter #(
  // Extra cycles each SRAM access is held, legal range 0..3.
  parameter int unsigned SRAM_WAIT = 1
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        cpu_rd,
  input  logic        cpu_wt,
  input  logic        cpu_byte,
  input  logic [15:0] cpu_adr,
  input  logic [15:0] cpu_data_i,
  output logic [15:0] cpu_data_o,
  output logic        cpu_reply,
  input  logic        vid_req,
  input  logic [14:0] vid_adr,
  output logic [15:0] vid_data,
  output logic        vid_valid,
  output logic [14:0] sram_a,
  output logic [15:0] sram_dq_o,
  input  logic [15:0] sram_dq_i,
  output logic        sram_dq_oe,
  output logic        sram_we_n,
  output logic        sram_oe_n,
  output logic        sram_ub_n,
  output logic        sram_lb_n,
  output logic [2:0]  dbg_state_o
);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_VID      = 3'd1,
    S_CPU_RD   = 3'd2,
    S_CPU_WR   = 3'd3,
    S_CPU_HOLD = 3'd4
  } state_t;

  // Counter load values: an access lasts load+1 cycles. Writes always get at
  // least two cycles so the address is set up before we_n falls.
  localparam logic [1:0] ACC_LOAD = 2'(SRAM_WAIT);
  localparam logic [1:0] WR_LOAD  = (SRAM_WAIT == 0) ? 2'd1 : 2'(SRAM_WAIT);

  state_t      state_q, state_d;
  logic [1:0]  cnt_q, cnt_d;
  logic        vid_pend_q, vid_pend_d;
  logic        last_vid_q, last_vid_d;
  logic        cpu_reply_q, cpu_reply_d;
  logic        vid_valid_q, vid_valid_d;
  logic [15:0] cpu_data_q, cpu_data_d;
  logic [15:0] vid_data_q, vid_data_d;
  logic [14:0] sram_a_q, sram_a_d;
  logic [15:0] sram_dq_o_q, sram_dq_o_d;
  logic        dq_oe_q, dq_oe_d;
  logic        we_n_q, we_n_d;
  logic        oe_n_q, oe_n_d;
  logic        ub_n_q, ub_n_d;
  logic        lb_n_q, lb_n_d;

  logic        vid_pending;
  logic        cpu_pending;
  logic        last_cycle;

  // Bit 15 selects non-RAM space and is decoded before this block.
  logic        unused_adr_msb;
  assign unused_adr_msb = cpu_adr[15];

  // A request pulse in the current cycle counts as pending immediately.
  assign vid_pending = vid_pend_q | vid_req;
  assign cpu_pending = (cpu_rd | cpu_wt) && (state_q != S_CPU_HOLD);
  assign last_cycle  = (cnt_q == 2'd0);

  // Next-state logic.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    last_vid_d = last_vid_q;
    vid_pend_d = vid_pend_q | vid_req;
    case (state_q)
      S_IDLE: begin
        // Video wins a tie unless it also won the previous grant.
        if (vid_pending && (!cpu_pending || !last_vid_q)) begin
          state_d    = S_VID;
          cnt_d      = ACC_LOAD;
          last_vid_d = 1'b1;
          vid_pend_d = 1'b0;
        end else if (cpu_pending) begin
          // Both strobes high is treated as a write.
          state_d    = cpu_wt ? S_CPU_WR : S_CPU_RD;
          cnt_d      = cpu_wt ? WR_LOAD : ACC_LOAD;
          last_vid_d = 1'b0;
        end
      end
      S_VID, S_CPU_RD, S_CPU_WR: begin
        // The access always runs to completion, even if the strobe drops.
        if (last_cycle) begin
          state_d = (state_q == S_VID) ? S_IDLE : S_CPU_HOLD;
        end else begin
          cnt_d = cnt_q - 2'd1;
        end
      end
      S_CPU_HOLD: begin
        if (!cpu_rd && !cpu_wt) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Registered outputs are computed from the state being entered, so every
  // SRAM pin is valid for the whole access window.
  always_comb begin
    sram_a_d    = sram_a_q;
    sram_dq_o_d = sram_dq_o_q;
    dq_oe_d     = 1'b0;
    we_n_d      = 1'b1;
    oe_n_d      = 1'b1;
    ub_n_d      = 1'b1;
    lb_n_d      = 1'b1;
    cpu_reply_d = (state_d == S_CPU_HOLD);
    vid_valid_d = (state_q == S_VID) && last_cycle;
    vid_data_d  = vid_data_q;
    cpu_data_d  = cpu_data_q;

    if ((state_q == S_VID) && last_cycle) begin
      vid_data_d = sram_dq_i;
    end
    if ((state_q == S_CPU_RD) && last_cycle) begin
      cpu_data_d = sram_dq_i;
    end

    case (state_d)
      S_VID: begin
        sram_a_d = vid_adr;
        oe_n_d   = 1'b0;
        ub_n_d   = 1'b0;
        lb_n_d   = 1'b0;
      end
      S_CPU_RD: begin
        sram_a_d = cpu_adr[15:1];
        oe_n_d   = 1'b0;
        ub_n_d   = 1'b0;
        lb_n_d   = 1'b0;
      end
      S_CPU_WR: begin
        sram_a_d    = cpu_adr[15:1];
        sram_dq_o_d = cpu_data_i;
        dq_oe_d     = 1'b1;
        // First write cycle is address setup; we_n falls afterwards.
        we_n_d      = (state_q != S_CPU_WR);
        if (cpu_byte) begin
          ub_n_d = ~cpu_adr[0];
          lb_n_d = cpu_adr[0];
        end else begin
          ub_n_d = 1'b0;
          lb_n_d = 1'b0;
        end
      end
      default: begin
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= S_IDLE;
      cnt_q       <= 2'd0;
      vid_pend_q  <= 1'b0;
      last_vid_q  <= 1'b0;
      cpu_reply_q <= 1'b0;
      vid_valid_q <= 1'b0;
      cpu_data_q  <= 16'h0000;
      vid_data_q  <= 16'h0000;
      sram_a_q    <= 15'h0000;
      sram_dq_o_q <= 16'h0000;
      dq_oe_q     <= 1'b0;
      we_n_q      <= 1'b1;
      oe_n_q      <= 1'b1;
      ub_n_q      <= 1'b1;
      lb_n_q      <= 1'b1;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      vid_pend_q  <= vid_pend_d;
      last_vid_q  <= last_vid_d;
      cpu_reply_q <= cpu_reply_d;
      vid_valid_q <= vid_valid_d;
      cpu_data_q  <= cpu_data_d;
      vid_data_q  <= vid_data_d;
      sram_a_q    <= sram_a_d;
      sram_dq_o_q <= sram_dq_o_d;
      dq_oe_q     <= dq_oe_d;
      we_n_q      <= we_n_d;
      oe_n_q      <= oe_n_d;
      ub_n_q      <= ub_n_d;
      lb_n_q      <= lb_n_d;
    end
  end

  assign cpu_data_o  = cpu_data_q;
  assign cpu_reply   = cpu_reply_q;
  assign vid_data    = vid_data_q;
  assign vid_valid   = vid_valid_q;
  assign sram_a      = sram_a_q;
  assign sram_dq_o   = sram_dq_o_q;
  assign sram_dq_oe  = dq_oe_q;
  assign sram_we_n   = we_n_q;
  assign sram_oe_n   = oe_n_q;
  assign sram_ub_n   = ub_n_q;
  assign sram_lb_n   = lb_n_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_ram_arbiter.sv
// Directed testbench for ram_arbiter (SRAM_WAIT = 1) with a behavioural
// SRAM model and a scoreboard queue for video fetches.
module tb_ram_arbiter;

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_VID  = 3'd1;
  localparam logic [2:0] S_RD   = 3'd2;
  localparam logic [2:0] S_WR   = 3'd3;
  localparam logic [2:0] S_HOLD = 3'd4;

  logic        clk;
  logic        reset_n;
  logic        cpu_rd, cpu_wt, cpu_byte;
  logic [15:0] cpu_adr, cpu_data_i, cpu_data_o;
  logic        cpu_reply;
  logic        vid_req;
  logic [14:0] vid_adr;
  logic [15:0] vid_data;
  logic        vid_valid;
  logic [14:0] sram_a;
  logic [15:0] sram_dq_o, sram_dq_i;
  logic        sram_dq_oe, sram_we_n, sram_oe_n, sram_ub_n, sram_lb_n;
  logic [2:0]  dbg_state;

  int          n_cmp = 0;
  int          n_err = 0;
  logic [15:0] exp_q[$];
  logic [2:0]  grant_log[$];
  logic [2:0]  prev_state = S_IDLE;
  logic        fair_mode = 1'b0;
  logic        cpu_done = 1'b0;

  // SRAM model
  logic [15:0] mem [0:32767];
  logic        pl_en = 1'b0;
  logic [14:0] pl_adr = '0;
  logic [15:0] pl_dat = '0;

  ram_arbiter #(.SRAM_WAIT(1)) dut (
    .clk(clk), .reset_n(reset_n),
    .cpu_rd(cpu_rd), .cpu_wt(cpu_wt), .cpu_byte(cpu_byte),
    .cpu_adr(cpu_adr), .cpu_data_i(cpu_data_i), .cpu_data_o(cpu_data_o),
    .cpu_reply(cpu_reply),
    .vid_req(vid_req), .vid_adr(vid_adr), .vid_data(vid_data),
    .vid_valid(vid_valid),
    .sram_a(sram_a), .sram_dq_o(sram_dq_o), .sram_dq_i(sram_dq_i),
    .sram_dq_oe(sram_dq_oe), .sram_we_n(sram_we_n), .sram_oe_n(sram_oe_n),
    .sram_ub_n(sram_ub_n), .sram_lb_n(sram_lb_n),
    .dbg_state_o(dbg_state)
  );

  // Clock / watchdog
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #300000;
    $display("FAIL watchdog: sim time limit reached, summary not reached");
    $fatal(1, "watchdog expired");
  end

  always @(posedge clk) begin
    if (pl_en) begin
      mem[pl_adr] <= pl_dat;
    end else if (!sram_we_n) begin
      if (!sram_ub_n) mem[sram_a][15:8] <= sram_dq_o[15:8];
      if (!sram_lb_n) mem[sram_a][7:0]  <= sram_dq_o[7:0];
    end
  end
  assign sram_dq_i = sram_oe_n ? 16'h0000 : mem[sram_a];

  task automatic check_eq(input string tag, input logic [31:0] got,
                          input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Monitor: video scoreboard, write-strobe sanity, grant order log.
  always @(negedge clk) begin
    if (reset_n) begin
      if (vid_valid) begin
        if (fair_mode) check_eq("vid_data_fair", vid_data, 16'h5678);
        else if (exp_q.size() == 0) check_eq("vid_valid_unexpected", vid_valid, 1'b0);
        else check_eq("vid_data", vid_data, exp_q.pop_front());
      end
      if (!sram_we_n) check_eq("we_needs_dq_oe", sram_dq_oe, 1'b1);
      if (prev_state == S_IDLE && dbg_state != S_IDLE) grant_log.push_back(dbg_state);
    end
    prev_state = dbg_state;
  end

  // Driver tasks: all are entered and left on a falling edge.
  task automatic preload(input logic [14:0] a, input logic [15:0] d);
    pl_en = 1'b1; pl_adr = a; pl_dat = d;
    @(negedge clk);
    pl_en = 1'b0;
  endtask

  task automatic cpu_read(input logic [15:0] adr, output logic [15:0] data);
    cpu_adr = adr; cpu_rd = 1'b1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (cpu_reply) break;
    end
    check_eq("rd_reply", cpu_reply, 1'b1);
    data = cpu_data_o;
    cpu_rd = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (!cpu_reply) break;
    end
    check_eq("rd_release", cpu_reply, 1'b0);
  endtask

  task automatic cpu_write(input logic [15:0] adr, input logic [15:0] d,
                           input logic byte_en);
    cpu_adr = adr; cpu_data_i = d; cpu_byte = byte_en; cpu_wt = 1'b1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (cpu_reply) break;
    end
    check_eq("wr_reply", cpu_reply, 1'b1);
    cpu_wt = 1'b0; cpu_byte = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (!cpu_reply) break;
    end
    check_eq("wr_release", cpu_reply, 1'b0);
  endtask

  logic [15:0] rdata;
  int          n_cpu, n_vid, n_pairs, rep_cnt;
  logic [2:0]  last_g;

  initial begin
    reset_n = 1'b0;
    cpu_rd = 1'b0; cpu_wt = 1'b0; cpu_byte = 1'b0;
    cpu_adr = '0; cpu_data_i = '0; vid_req = 1'b0; vid_adr = '0;
    repeat (3) @(negedge clk);

    // Reset state
    check_eq("rst_state", dbg_state, S_IDLE);
    check_eq("rst_reply", cpu_reply, 1'b0);
    check_eq("rst_vid_valid", vid_valid, 1'b0);
    check_eq("rst_we_n", sram_we_n, 1'b1);
    check_eq("rst_oe_n", sram_oe_n, 1'b1);
    check_eq("rst_ub_lb", {sram_ub_n, sram_lb_n}, 2'b11);
    check_eq("rst_dq_oe", sram_dq_oe, 1'b0);
    check_eq("rst_cpu_data", cpu_data_o, 16'h0000);
    check_eq("rst_vid_data", vid_data, 16'h0000);
    check_eq("rst_sram_a", sram_a, 15'h0000);
    check_eq("rst_dq_o", sram_dq_o, 16'h0000);
    reset_n = 1'b1;

    preload(15'h0100, 16'h1234);
    preload(15'h0200, 16'h5678);
    preload(15'h0300, 16'hBEEF);

    // Word read, two-cycle access
    cpu_adr = 16'h0200; cpu_rd = 1'b1;
    @(negedge clk);
    check_eq("rd1_state", dbg_state, S_RD);
    check_eq("rd1_oe_c1", sram_oe_n, 1'b0);
    check_eq("rd1_addr", sram_a, 15'h0100);
    check_eq("rd1_ub_lb", {sram_ub_n, sram_lb_n}, 2'b00);
    check_eq("rd1_we_n", sram_we_n, 1'b1);
    @(negedge clk);
    check_eq("rd1_oe_c2", sram_oe_n, 1'b0);
    @(negedge clk);
    check_eq("rd1_hold", dbg_state, S_HOLD);
    check_eq("rd1_reply", cpu_reply, 1'b1);
    check_eq("rd1_data", cpu_data_o, 16'h1234);
    check_eq("rd1_oe_off", sram_oe_n, 1'b1);
    cpu_rd = 1'b0;
    @(negedge clk);
    check_eq("rd1_reply_drop", cpu_reply, 1'b0);
    check_eq("rd1_idle", dbg_state, S_IDLE);

    // High-byte write
    cpu_wt = 1'b1; cpu_byte = 1'b1; cpu_adr = 16'h0201; cpu_data_i = 16'hABAB;
    @(negedge clk);
    check_eq("bw_state", dbg_state, S_WR);
    check_eq("bw_we_c1", sram_we_n, 1'b1);
    check_eq("bw_ub_lb", {sram_ub_n, sram_lb_n}, 2'b01);
    check_eq("bw_dq_oe", sram_dq_oe, 1'b1);
    check_eq("bw_dq_o", sram_dq_o, 16'hABAB);
    check_eq("bw_addr", sram_a, 15'h0100);
    @(negedge clk);
    check_eq("bw_we_c2", sram_we_n, 1'b0);
    @(negedge clk);
    check_eq("bw_we_off", sram_we_n, 1'b1);
    check_eq("bw_dq_oe_off", sram_dq_oe, 1'b0);
    check_eq("bw_reply", cpu_reply, 1'b1);
    cpu_wt = 1'b0; cpu_byte = 1'b0;
    @(negedge clk);
    check_eq("bw_reply_drop", cpu_reply, 1'b0);
    check_eq("bw_mem", mem[15'h0100], 16'hAB34);

    // Contention: video first, then CPU; second video waits for HOLD exit
    exp_q.push_back(16'h5678);
    vid_adr = 15'h0200; vid_req = 1'b1; cpu_adr = 16'h0600; cpu_rd = 1'b1;
    @(negedge clk);
    vid_req = 1'b0;
    check_eq("ct_vid_first", dbg_state, S_VID);
    check_eq("ct_vid_addr", sram_a, 15'h0200);
    @(negedge clk);
    @(negedge clk);
    check_eq("ct_vid_valid", vid_valid, 1'b1);
    check_eq("ct_idle", dbg_state, S_IDLE);
    @(negedge clk);
    check_eq("ct_cpu_next", dbg_state, S_RD);
    check_eq("ct_cpu_addr", sram_a, 15'h0300);
    repeat (2) @(negedge clk);
    check_eq("ct_hold", dbg_state, S_HOLD);
    check_eq("ct_cpu_data", cpu_data_o, 16'hBEEF);
    exp_q.push_back(16'hAB34);
    vid_adr = 15'h0100; vid_req = 1'b1;
    @(negedge clk);
    vid_req = 1'b0;
    check_eq("ct_hold_keeps", dbg_state, S_HOLD);
    cpu_rd = 1'b0;
    @(negedge clk);
    check_eq("ct_exit_idle", dbg_state, S_IDLE);
    @(negedge clk);
    check_eq("ct_vid2", dbg_state, S_VID);
    repeat (3) @(negedge clk);
    check_eq("ct_scoreboard_empty", exp_q.size(), 0);

    // Fairness: video every 3 cycles while CPU reads back-to-back
    grant_log.delete();
    fair_mode = 1'b1;
    fork
      begin
        for (int k = 0; k < 10; k++) begin
          cpu_read(16'h0600, rdata);
          check_eq("fair_cpu_data", rdata, 16'hBEEF);
        end
        cpu_done = 1'b1;
      end
      begin
        while (!cpu_done) begin
          vid_adr = 15'h0200; vid_req = 1'b1;
          @(negedge clk);
          vid_req = 1'b0;
          repeat (2) @(negedge clk);
        end
      end
    join
    repeat (12) @(negedge clk);
    fair_mode = 1'b0;
    n_cpu = 0; n_vid = 0; n_pairs = 0; last_g = S_IDLE;
    foreach (grant_log[i]) begin
      if (n_cpu < 10) begin
        if (grant_log[i] == S_RD) n_cpu++;
        if (grant_log[i] == S_VID) begin
          n_vid++;
          if (last_g == S_VID) n_pairs++;
        end
        last_g = grant_log[i];
      end
    end
    check_eq("fair_first_cpu", grant_log[0], S_RD);
    check_eq("fair_cpu_grants", n_cpu, 10);
    check_eq("fair_vid_between", n_vid, 9);
    check_eq("fair_vid_pairs", n_pairs, 0);

    // Strobe dropped on the first read cycle
    cpu_adr = 16'h0200; cpu_rd = 1'b1;
    @(negedge clk);
    check_eq("sd_state", dbg_state, S_RD);
    cpu_rd = 1'b0;
    @(negedge clk);
    check_eq("sd_continues", dbg_state, S_RD);
    @(negedge clk);
    check_eq("sd_reply", cpu_reply, 1'b1);
    check_eq("sd_data", cpu_data_o, 16'hAB34);
    @(negedge clk);
    check_eq("sd_reply_1cyc", cpu_reply, 1'b0);
    check_eq("sd_idle", dbg_state, S_IDLE);

    // Reset pulsed during a write
    cpu_wt = 1'b1; cpu_adr = 16'h0800; cpu_data_i = 16'h1111;
    @(negedge clk);
    check_eq("ab_state", dbg_state, S_WR);
    @(negedge clk);
    check_eq("ab_we_low", sram_we_n, 1'b0);
    #2 reset_n = 1'b0;
    #1;
    check_eq("ab_we_high", sram_we_n, 1'b1);
    check_eq("ab_dq_oe", sram_dq_oe, 1'b0);
    check_eq("ab_state_idle", dbg_state, S_IDLE);
    @(negedge clk);
    cpu_wt = 1'b0; reset_n = 1'b1;
    rep_cnt = 0;
    repeat (6) begin
      @(negedge clk);
      if (cpu_reply) rep_cnt++;
    end
    check_eq("ab_no_reply", rep_cnt, 0);
    check_eq("ab_final_idle", dbg_state, S_IDLE);

    // Word write with both strobes high, then read back
    cpu_rd = 1'b1; cpu_wt = 1'b1; cpu_byte = 1'b0;
    cpu_adr = 16'h0A00; cpu_data_i = 16'hC0DE;
    @(negedge clk);
    check_eq("ww_is_write", dbg_state, S_WR);
    check_eq("ww_ub_lb", {sram_ub_n, sram_lb_n}, 2'b00);
    for (int i = 0; i < 40; i++) begin
      if (cpu_reply) break;
      @(negedge clk);
    end
    check_eq("ww_reply", cpu_reply, 1'b1);
    cpu_rd = 1'b0; cpu_wt = 1'b0;
    @(negedge clk);
    check_eq("ww_mem", mem[15'h0500], 16'hC0DE);
    cpu_read(16'h0A00, rdata);
    check_eq("ww_readback", rdata, 16'hC0DE);

    // Low-byte write, then read back
    cpu_write(16'h0200, 16'h5555, 1'b1);
    check_eq("lb_mem", mem[15'h0100], 16'hAB55);
    cpu_read(16'h0200, rdata);
    check_eq("lb_readback", rdata, 16'hAB55);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/ram_arbiter.md
RAM_ARBITER -- requirements
Module: ram_arbiter

Interface
REQ-001 Parameter: SRAM_WAIT, default 1, number of extra clk cycles an SRAM access is held; legal range 0..3.
REQ-002 clk  in  1  core clock, all state changes on rising edge.
REQ-003 reset_n  in  1  asynchronous, active-low reset.
REQ-004 cpu_rd  in  1  CPU read strobe (DIN), level, held until reply seen.
REQ-005 cpu_wt  in  1  CPU write strobe (DOUT), level, held until reply seen.
REQ-006 cpu_byte  in  1  byte access; cpu_adr[0] selects the high byte.
REQ-007 cpu_adr  in  16  CPU byte address; bit 15 must be 0 (RAM space).
REQ-008 cpu_data_i  in  16  write data, byte already replicated to both lanes.
REQ-009 cpu_data_o  out  16  read data, full word.
REQ-010 cpu_reply  out  1  bus reply (RPLY) to CPU.
REQ-011 vid_req  in  1  video fetch request, single-cycle pulse.
REQ-012 vid_adr  in  15  video word address.
REQ-013 vid_data  out  16  fetched video word.
REQ-014 vid_valid  out  1  one-cycle strobe; vid_data valid.
REQ-015 sram_a  out  15  SRAM word address.
REQ-016 sram_dq_o / sram_dq_i  out/in  16  SRAM data out/in.
REQ-017 sram_dq_oe  out  1  drive sram_dq_o onto the bus.
REQ-018 sram_we_n, sram_oe_n, sram_ub_n, sram_lb_n  out  1 each  SRAM controls, active-low.

Function
REQ-019 States: IDLE, VID, CPU_RD, CPU_WR, CPU_HOLD; an access state lasts SRAM_WAIT+1 cycles, counted by a 2-bit counter loaded on entry.
REQ-020 A vid_req pulse sets a pending flag; the flag clears when VID is entered; a second pulse while pending is lost, with no error.
REQ-021 CPU pending = (cpu_rd | cpu_wt) and not in CPU_HOLD; cpu_rd and cpu_wt both high counts as a write.
REQ-022 From IDLE, if only one requester is pending, that requester is granted.
REQ-023 From IDLE, if both are pending, video is granted unless the previous grant was video; then CPU is granted (no more than one consecutive video grant while the CPU waits).
REQ-024 VID: sram_a=vid_adr, oe_n=0, ub_n=lb_n=0, we_n=1; on the last cycle sram_dq_i is captured into vid_data; vid_valid pulses on the next cycle; return to IDLE.
REQ-025 CPU_RD: sram_a=cpu_adr[15:1], oe_n=0, ub_n=lb_n=0; on the last cycle the word is captured into cpu_data_o; then go to CPU_HOLD.
REQ-026 CPU_WR: sram_a=cpu_adr[15:1], dq_oe=1, dq_o=cpu_data_i.
REQ-027 CPU_WR byte enables: for word writes, ub_n=lb_n=0; for byte writes, ub_n=~cpu_adr[0] and lb_n=cpu_adr[0].
REQ-028 CPU_WR strobe: we_n=0 on every cycle except the first, giving address setup before we_n falls; then go to CPU_HOLD.
REQ-029 When SRAM_WAIT=0 the write state lasts 2 cycles, not 1, so that setup is preserved.
REQ-030 CPU_HOLD: cpu_reply=1 and SRAM idle; when cpu_rd and cpu_wt are both 0, cpu_reply drops on the next cycle and the state returns to IDLE.
REQ-031 A CPU strobe deasserted mid-access does not abort the access; the access completes, passes through CPU_HOLD, and exits CPU_HOLD immediately.
REQ-032 SRAM idle encoding: oe_n=we_n=ub_n=lb_n=1, dq_oe=0; sram_we_n is never 0 in the same cycle as sram_dq_oe=0.
REQ-033 All SRAM and handshake outputs are registered.
REQ-034 cpu_data_o and vid_data hold their value until the next capture.

Reset
REQ-035 On reset_n=0, asynchronously: state=IDLE, cpu_reply=0, vid_valid=0, pending flag=0, last-grant=CPU, SRAM outputs in the idle encoding, and cpu_data_o, vid_data, sram_a and sram_dq_o cleared to 0.
REQ-036 A reset asserted mid-access abandons the access with no reply or valid strobe.

Verification
REQ-037 Word read, SRAM_WAIT=1: SRAM holds 0x1234 at word 0x0100; cpu_rd with cpu_adr=0x0200 -> oe_n low for 2 cycles, cpu_reply=1 with cpu_data_o=0x1234, reply drops 1 cycle after cpu_rd falls.
REQ-038 Byte write: cpu_wt, cpu_byte, cpu_adr=0x0201, data 0xABAB -> ub_n=0, lb_n=1, we_n low on cycle 2 only, SRAM word 0x0100 = 0xAB34.
REQ-039 Contention: vid_req and cpu_rd in the same cycle, last grant=CPU -> VID first, vid_valid pulses, then CPU_RD; a second vid_req during CPU_HOLD is served after the CPU exits.
REQ-040 Fairness: vid_req every 3 cycles with the CPU reading continuously -> grants alternate video/CPU, the CPU is never starved.
REQ-041 Abort: reset_n pulsed low during CPU_WR -> we_n=1 immediately, cpu_reply never asserts, state=IDLE.
REQ-042 Strobe drop: cpu_rd dropped on the first cycle of CPU_RD -> the access completes, cpu_reply asserts for exactly 1 cycle, then IDLE.
